// File: rtl/dcm_phaseshift_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcm_phaseshift_multi_pkg
// Description : Shared definitions for the multi-channel DCM phase-shift
//               controller: channel FSM state encoding, the target clamp
//               helper and the PSDONE timeout counter width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dcm_phaseshift_multi_pkg;

  // Per-channel walker states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STEP     = 2'd1,
    ST_WAIT     = 2'd2,
    ST_UNLOCKED = 2'd3
  } ps_state_e;

  localparam int DEFAULT_DONE_TIMEOUT = 255;

  // Bits needed to count from 0 up to and including the timeout value.
  function automatic int timeout_width(input int timeout);
    if (timeout < 1) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

  localparam int TIMEOUT_W = timeout_width(DEFAULT_DONE_TIMEOUT);

  // Saturate a signed phase request to +/-limit.
  function automatic int clamp_phase(input int value, input int limit);
    if (value > limit) begin
      return limit;
    end
    if (value < -limit) begin
      return -limit;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcm_phaseshift_chan.sv
`default_nettype none
// ============================================================================
// Module      : dcm_phaseshift_chan
// Description : One DCM phase-shift channel. Walks the confirmed phase one
//               PSEN/PSDONE handshake at a time toward a clamped signed
//               target, with PSDONE timeout, overflow trapping and return to
//               phase 0 on loss of lock.
// Ports       : clk, reset_n          - clock / async active-low reset
//               load_value, load      - signed target request and strobe
//               err_clr               - clears the sticky error flag
//               phase                 - confirmed phase
//               busy, done, err       - status
//               psen, psincdec        - registered DCM phase-shift controls
//               psdone, ovf, locked   - DCM feedback
// Revision    : 1.0 - initial release
// ============================================================================
module dcm_phaseshift_chan
  import dcm_phaseshift_multi_pkg::*;
#(
  parameter int PHASE_W      = 10,
  parameter int PS_LIMIT     = 255,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PHASE_W-1:0] load_value,
  input  logic               load,
  input  logic               err_clr,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               psen,
  output logic               psincdec,
  input  logic               psdone,
  input  logic               ovf,
  input  logic               locked
);

  localparam int                   CNT_W     = timeout_width(DONE_TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(DONE_TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic signed [PHASE_W-1:0] STEP_ONE = PHASE_W'(1);

  ps_state_e                  state, state_next;
  logic signed [PHASE_W-1:0]  target, target_next;
  logic signed [PHASE_W-1:0]  actual, actual_next;
  logic [CNT_W-1:0]           cnt, cnt_next;
  logic                       psen_next;
  logic                       psincdec_next;
  logic                       done_next;
  logic                       err_set;
  logic                       err_next;
  logic signed [PHASE_W-1:0]  load_clamped;
  logic signed [PHASE_W-1:0]  stepped;

  assign load_clamped = PHASE_W'(clamp_phase(int'($signed(load_value)), PS_LIMIT));

  // Phase the DCM reaches once the outstanding step is confirmed.
  assign stepped = psincdec ? (actual + STEP_ONE) : (actual - STEP_ONE);

  always_comb begin
    state_next    = state;
    // A load is accepted in every state; overflow/timeout below override it.
    target_next   = load ? load_clamped : target;
    actual_next   = actual;
    cnt_next      = cnt;
    psen_next     = 1'b0;
    psincdec_next = psincdec;
    done_next     = 1'b0;
    err_set       = 1'b0;

    if (!locked) begin
      // DCM reset returns its phase to zero; target survives for restore.
      state_next  = ST_UNLOCKED;
      actual_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Decide on the incoming target so PSEN follows the load by one cycle.
          if (target_next != actual) begin
            state_next    = ST_STEP;
            psen_next     = 1'b1;
            psincdec_next = (target_next > actual);
          end else if (load) begin
            done_next = 1'b1;
          end
        end

        ST_STEP: begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end

        ST_WAIT: begin
          if (psdone) begin
            actual_next = stepped;
            if (ovf) begin
              err_set     = 1'b1;
              target_next = stepped;
              state_next  = ST_IDLE;
              done_next   = 1'b1;
            end else if (stepped != target_next) begin
              state_next    = ST_STEP;
              psen_next     = 1'b1;
              psincdec_next = (target_next > stepped);
            end else begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end else if (cnt == CNT_LIMIT) begin
            err_set     = 1'b1;
            target_next = actual;
            state_next  = ST_IDLE;
            done_next   = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end

        ST_UNLOCKED: begin
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    // An error event in the same cycle as a clear keeps the flag set.
    if (err_set) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end else begin
      err_next = err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      target   <= '0;
      actual   <= '0;
      cnt      <= '0;
      psen     <= 1'b0;
      psincdec <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      target   <= target_next;
      actual   <= actual_next;
      cnt      <= cnt_next;
      psen     <= psen_next;
      psincdec <= psincdec_next;
      done     <= done_next;
      err      <= err_next;
    end
  end

  assign phase = actual;
  assign busy  = (actual != target) || (state == ST_STEP) || (state == ST_WAIT);

endmodule
`default_nettype wire

// File: rtl/dcm_phaseshift_multi.sv
`default_nettype none
// ============================================================================
// Module      : dcm_phaseshift_multi
// Description : Multi-channel DCM variable phase-shift controller. Each
//               channel independently steps its DCM toward a host-written
//               signed target; clk_i also drives every DCM PSCLK.
// Ports       : clk_i, reset_n_i     - clock / async active-low reset
//               value_i, load_i      - packed signed targets and load strobes
//               err_clr_i            - clears all error flags
//               value_o              - packed confirmed phase per channel
//               busy_o, done_o, err_o- per-channel status
//               dcm_psen_o, dcm_psincdec_o - to DCM PSEN / PSINCDEC
//               dcm_psdone_i, dcm_ovf_i, dcm_locked_i - from DCM
// Revision    : 1.0 - initial release
// ============================================================================
module dcm_phaseshift_multi
  import dcm_phaseshift_multi_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int PHASE_W      = 10,
  parameter int PS_LIMIT     = 255,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [NUM_CH*PHASE_W-1:0] value_i,
  input  logic [NUM_CH-1:0]         load_i,
  input  logic                      err_clr_i,
  output logic [NUM_CH*PHASE_W-1:0] value_o,
  output logic [NUM_CH-1:0]         busy_o,
  output logic [NUM_CH-1:0]         done_o,
  output logic [NUM_CH-1:0]         err_o,
  output logic [NUM_CH-1:0]         dcm_psen_o,
  output logic [NUM_CH-1:0]         dcm_psincdec_o,
  input  logic [NUM_CH-1:0]         dcm_psdone_i,
  input  logic [NUM_CH-1:0]         dcm_ovf_i,
  input  logic [NUM_CH-1:0]         dcm_locked_i
);

  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_chan
      dcm_phaseshift_chan #(
        .PHASE_W      (PHASE_W),
        .PS_LIMIT     (PS_LIMIT),
        .DONE_TIMEOUT (DONE_TIMEOUT)
      ) u_chan (
        .clk        (clk_i),
        .reset_n    (reset_n_i),
        .load_value (value_i[ch*PHASE_W +: PHASE_W]),
        .load       (load_i[ch]),
        .err_clr    (err_clr_i),
        .phase      (value_o[ch*PHASE_W +: PHASE_W]),
        .busy       (busy_o[ch]),
        .done       (done_o[ch]),
        .err        (err_o[ch]),
        .psen       (dcm_psen_o[ch]),
        .psincdec   (dcm_psincdec_o[ch]),
        .psdone     (dcm_psdone_i[ch]),
        .ovf        (dcm_ovf_i[ch]),
        .locked     (dcm_locked_i[ch])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dcm_phaseshift_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcm_phaseshift_multi
// Description : Self-checking bench for dcm_phaseshift_multi. A behavioural
//               DCM model per channel answers PSEN with PSDONE after a
//               programmable latency and tracks the true DCM phase; expected
//               results come from the clamped targets and step arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcm_phaseshift_multi;

  localparam int NUM_CH       = 2;
  localparam int PHASE_W      = 10;
  localparam int PS_LIMIT     = 255;
  localparam int DONE_TIMEOUT = 255;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_CH*PHASE_W-1:0] value;
  logic [NUM_CH-1:0]         load;
  logic                      err_clr;
  logic [NUM_CH*PHASE_W-1:0] value_o;
  logic [NUM_CH-1:0]         busy_o, done_o, err_o, psen, psincdec;
  logic [NUM_CH-1:0]         psdone, ovf, locked;

  always #5 clk = ~clk;

  dcm_phaseshift_multi #(
    .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .PS_LIMIT(PS_LIMIT), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .value_i(value), .load_i(load),
    .err_clr_i(err_clr), .value_o(value_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .dcm_psen_o(psen), .dcm_psincdec_o(psincdec),
    .dcm_psdone_i(psdone), .dcm_ovf_i(ovf), .dcm_locked_i(locked)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // DCM model and reference state
  int phase[NUM_CH];
  int tgt[NUM_CH];
  int pmax[NUM_CH];
  int lat[NUM_CH];
  int wcnt[NUM_CH];
  int dir[NUM_CH];
  int psen_cyc[NUM_CH];
  int ovf_at[NUM_CH];
  bit ovf_en[NUM_CH];
  bit drop[NUM_CH];
  bit outst[NUM_CH];
  int psen_cnt[NUM_CH];
  int done_cnt[NUM_CH];
  int to_cnt[NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int clamp_ref(input int v);
    if (v > PS_LIMIT) return PS_LIMIT;
    if (v < -PS_LIMIT) return -PS_LIMIT;
    return v;
  endfunction

  function automatic int val_of(input int c);
    logic signed [PHASE_W-1:0] t;
    t = value_o[c*PHASE_W +: PHASE_W];
    return int'(t);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // DCM behavioural model, evaluated 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        psdone[c] = 1'b0;
        ovf[c]    = 1'b0;
        if (!reset_n) begin
          phase[c] = 0; wcnt[c] = 0; outst[c] = 1'b0;
        end else begin
          if (!locked[c]) begin
            phase[c] = 0; wcnt[c] = 0; outst[c] = 1'b0;
          end
          if (done_o[c]) begin
            done_cnt[c]++;
            if (outst[c]) begin
              // step abandoned: controller gave up waiting for PSDONE
              check_val("timeout_window",
                        int'((cyc - psen_cyc[c]) >= DONE_TIMEOUT + 1 &&
                             (cyc - psen_cyc[c]) <= DONE_TIMEOUT + 3), 1);
              tgt[c] = phase[c]; outst[c] = 1'b0; wcnt[c] = 0; to_cnt[c]++;
            end
          end
          if (psen[c]) begin
            psen_cnt[c]++;
            check_val("psen_locked", int'(locked[c]), 1);
            check_val("psen_overlap", int'(outst[c]), 0);
            check_val("psen_needed", int'(tgt[c] != phase[c]), 1);
            check_val("psincdec", int'(psincdec[c]), int'(tgt[c] > phase[c]));
            outst[c] = 1'b1; psen_cyc[c] = cyc; dir[c] = psincdec[c] ? 1 : -1;
            if (!drop[c]) wcnt[c] = lat[c];
          end else if (wcnt[c] > 0) begin
            wcnt[c]--;
            if (wcnt[c] == 0) begin
              psdone[c] = 1'b1;
              phase[c] += dir[c];
              outst[c] = 1'b0;
              if (phase[c] > pmax[c]) pmax[c] = phase[c];
              if (ovf_en[c] && phase[c] == ovf_at[c]) begin
                ovf[c] = 1'b1;
                tgt[c] = phase[c];
              end
            end
          end
        end
      end
    end
  end

  task automatic load_multi(input int mask, input int vals[NUM_CH]);
    bit idle_b[NUM_CH];
    int cv[NUM_CH];
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        idle_b[c] = !busy_o[c];
        cv[c] = clamp_ref(vals[c]);
        value[c*PHASE_W +: PHASE_W] = PHASE_W'(vals[c]);
        load[c] = 1'b1;
        tgt[c] = cv[c];
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c] && idle_b[c] && locked[c]) begin
        check_val("psen_latency", int'(psen[c]), int'(cv[c] != phase[c]));
        check_val("busy_latency", int'(busy_o[c]), int'(cv[c] != phase[c]));
        check_val("done_equal_load", int'(done_o[c]), int'(cv[c] == phase[c]));
      end
    end
    @(negedge clk);
    load = '0;
  endtask

  task automatic do_load(input int c, input int v);
    int vals[NUM_CH];
    for (int k = 0; k < NUM_CH; k++) vals[k] = 0;
    vals[c] = v;
    load_multi(1 << c, vals);
  endtask

  task automatic wait_settle(input int c, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy_o[c] && n < budget);
    check_val("settle", int'(busy_o[c]), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_value(input int c, input int v, input int budget);
    int n = 0;
    while (val_of(c) != v && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("reach_value", val_of(c), v);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  int b_psen[NUM_CH];
  int b_done[NUM_CH];
  int start[NUM_CH];
  int rv[NUM_CH];

  task automatic snap();
    for (int c = 0; c < NUM_CH; c++) begin
      b_psen[c] = psen_cnt[c]; b_done[c] = done_cnt[c]; start[c] = phase[c];
    end
  endtask

  initial begin
    reset_n = 1'b0; value = '0; load = '0; err_clr = 1'b0;
    psdone = '0; ovf = '0; locked = '1;
    for (int c = 0; c < NUM_CH; c++) begin
      phase[c] = 0; tgt[c] = 0; pmax[c] = 0; lat[c] = 3; wcnt[c] = 0; dir[c] = 0;
      psen_cyc[c] = 0; ovf_at[c] = 0; ovf_en[c] = 1'b0; drop[c] = 1'b0; outst[c] = 1'b0;
      psen_cnt[c] = 0; done_cnt[c] = 0; to_cnt[c] = 0;
    end
    repeat (3) @(negedge clk);
    check_val("rst_value", int'(value_o), 0);
    check_val("rst_busy", int'(busy_o), 0);
    check_val("rst_done", int'(done_o), 0);
    check_val("rst_err", int'(err_o), 0);
    check_val("rst_psen", int'(psen), 0);
    check_val("rst_psincdec", int'(psincdec), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // +5 walk on ch0
    snap();
    do_load(0, 5);
    wait_settle(0, 200);
    check_val("inc5_value", val_of(0), 5);
    check_val("inc5_psen", psen_cnt[0] - b_psen[0], 5);
    check_val("inc5_done", done_cnt[0] - b_done[0], 1);
    check_val("inc5_err", int'(err_o[0]), 0);

    // clamped negative load, overflow trapped at -40
    ovf_at[0] = -40; ovf_en[0] = 1'b1;
    snap();
    do_load(0, -300);
    wait_settle(0, 2000);
    ovf_en[0] = 1'b0;
    check_val("ovf_value", val_of(0), -40);
    check_val("ovf_psen", psen_cnt[0] - b_psen[0], 45);
    check_val("ovf_done", done_cnt[0] - b_done[0], 1);
    check_val("ovf_err", int'(err_o[0]), 1);
    clear_err();
    check_val("ovf_err_clr", int'(err_o[0]), 0);

    // PSDONE never returns on ch1
    drop[1] = 1'b1;
    snap();
    do_load(1, 3);
    wait_settle(1, 400);
    repeat (30) @(negedge clk);
    check_val("to_value", val_of(1), 0);
    check_val("to_psen", psen_cnt[1] - b_psen[1], 1);
    check_val("to_done", done_cnt[1] - b_done[1], 1);
    check_val("to_count", to_cnt[1], 1);
    check_val("to_err", int'(err_o[1]), 1);
    drop[1] = 1'b0;
    clear_err();
    check_val("to_err_clr", int'(err_o[1]), 0);

    // retarget during an outstanding step
    do_load(0, 0);
    wait_settle(0, 1000);
    lat[0] = 4;
    snap();
    pmax[0] = phase[0];
    do_load(0, 20);
    wait_value(0, 8, 400);
    do_load(0, 3);
    wait_settle(0, 400);
    check_val("mid_value", val_of(0), 3);
    check_val("mid_peak", pmax[0], 9);
    check_val("mid_psen", psen_cnt[0] - b_psen[0], 15);
    check_val("mid_done", done_cnt[0] - b_done[0], 1);

    // lock loss at +12, restore after relock
    lat[0] = 2;
    do_load(0, 12);
    wait_settle(0, 400);
    check_val("pre_unlock_value", val_of(0), 12);
    snap();
    @(negedge clk);
    locked[0] = 1'b0;
    repeat (10) @(negedge clk);
    check_val("unlock_value", val_of(0), 0);
    check_val("unlock_busy", int'(busy_o[0]), 1);
    check_val("unlock_psen", psen_cnt[0] - b_psen[0], 0);
    locked[0] = 1'b1;
    wait_settle(0, 400);
    check_val("relock_value", val_of(0), 12);
    check_val("relock_psen", psen_cnt[0] - b_psen[0], 12);
    check_val("relock_err", int'(err_o[0]), 0);

    // simultaneous loads, different DCM latencies
    lat[0] = 1; lat[1] = 5;
    snap();
    rv[0] = 4; rv[1] = -4;
    load_multi(3, rv);
    wait_settle(0, 400);
    wait_settle(1, 400);
    check_val("dual_value0", val_of(0), 4);
    check_val("dual_value1", val_of(1), -4);
    check_val("dual_psen0", psen_cnt[0] - b_psen[0], 8);
    check_val("dual_psen1", psen_cnt[1] - b_psen[1], 4);

    // load equal to current phase
    snap();
    do_load(1, -4);
    repeat (3) @(negedge clk);
    check_val("eq_done", done_cnt[1] - b_done[1], 1);
    check_val("eq_psen", psen_cnt[1] - b_psen[1], 0);

    // randomized targets across the full input range
    for (int it = 0; it < 6; it++) begin
      int mask;
      mask = int'($urandom_range(1, 3));
      for (int c = 0; c < NUM_CH; c++) begin
        lat[c] = int'($urandom_range(1, 5));
        rv[c]  = int'($urandom_range(0, 1023)) - 512;
      end
      snap();
      load_multi(mask, rv);
      for (int c = 0; c < NUM_CH; c++) wait_settle(c, 6000);
      for (int c = 0; c < NUM_CH; c++) begin
        int exp_v;
        exp_v = mask[c] ? clamp_ref(rv[c]) : start[c];
        check_val("rnd_value", val_of(c), exp_v);
        check_val("rnd_psen", psen_cnt[c] - b_psen[c], iabs(exp_v - start[c]));
        check_val("rnd_done", done_cnt[c] - b_done[c], int'(mask[c]));
        check_val("rnd_err", int'(err_o[c]), 0);
      end
    end

    // asynchronous reset in the middle of a walk
    lat[0] = 3;
    do_load(0, -200);
    repeat (20) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("arst_value", int'(value_o), 0);
    check_val("arst_busy", int'(busy_o), 0);
    check_val("arst_psen", int'(psen), 0);
    check_val("arst_err", int'(err_o), 0);
    for (int c = 0; c < NUM_CH; c++) tgt[c] = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcm_phaseshift_multi.md
# dcm_phaseshift_multi

Multi-channel controller for DCM variable phase shift. It walks each DCM's phase one PSEN/PSDONE step at a time toward a signed, host-written target. It adds clamping, PSDONE timeout, overflow trapping and automatic phase restore after loss of lock. It sits between the register interface and up to NUM_CH DCM_SP instances in the clock-management layer, and its clock drives each DCM's PSCLK.

## Interface
Parameters:
- NUM_CH, 2: number of independent DCM channels (1-8).
- PHASE_W, 10: width of signed phase values (two's complement).
- PS_LIMIT, 255: maximum magnitude of the target; loads are clamped to ±PS_LIMIT.
- DONE_TIMEOUT, 255: cycles allowed from PSEN to PSDONE before the step aborts.

Ports (clock and reset first):
- clk_i  in  1  single clock for all logic; also drives DCM PSCLK.
- reset_n_i  in  1  asynchronous, active-low reset.
- value_i  in  NUM_CH*PHASE_W  packed signed target per channel; channel c occupies bits [c*PHASE_W +: PHASE_W].
- load_i  in  NUM_CH  one-cycle strobe per channel that latches the clamped value_i slice as the target.
- err_clr_i  in  1  clears all err_o bits.
- value_o  out  NUM_CH*PHASE_W  actual (confirmed) phase per channel.
- busy_o  out  NUM_CH  channel is moving (actual != target, or a step is outstanding).
- done_o  out  NUM_CH  one-cycle pulse when a channel settles.
- err_o  out  NUM_CH  sticky error flag (overflow or timeout).
- dcm_psen_o  out  NUM_CH  to DCM PSEN.
- dcm_psincdec_o  out  NUM_CH  to DCM PSINCDEC; valid whenever PSEN is high.
- dcm_psdone_i  in  NUM_CH  from DCM PSDONE.
- dcm_ovf_i  in  NUM_CH  DCM STATUS[0], phase-shift overflow.
- dcm_locked_i  in  NUM_CH  DCM LOCKED (qualified by the caller).

## Operation
- Channels are fully independent. Each channel has one FSM with states IDLE, STEP, WAIT and UNLOCKED. Each channel keeps a signed target and a signed actual register, both PHASE_W bits wide.
- Load: target <= clamp(value_i slice, -PS_LIMIT, +PS_LIMIT). A load is accepted in any state. A load during WAIT changes only the target; the outstanding step completes first.
- IDLE: if dcm_locked_i is high and actual != target, go to STEP.
- STEP: drive dcm_psen_o high for exactly one cycle. Drive dcm_psincdec_o = 1 if target > actual, else 0. Clear the timeout counter and go to WAIT.
- WAIT: dcm_psen_o is low. The timeout counter width is $clog2(DONE_TIMEOUT+1).
  - On dcm_psdone_i, actual <= actual ± 1.
  - If dcm_ovf_i is high in the PSDONE cycle, set err_o and target <= actual (new value). Go to IDLE and pulse done_o.
  - Otherwise, go to STEP if the new actual != target. If they are equal, go to IDLE and pulse done_o.
  - If the counter reaches DONE_TIMEOUT with no PSDONE, set err_o, leave actual unchanged, set target <= actual, go to IDLE and pulse done_o.
- Load equal to actual while in IDLE: pulse done_o in the following cycle. No PSEN is issued.
- Lock loss: dcm_locked_i low in any state moves the FSM to UNLOCKED and aborts any outstanding step. Actual is set to 0, because a DCM reset returns its phase to 0. Target is kept and err_o is not set.
- UNLOCKED: when dcm_locked_i returns high, go to IDLE. The channel then walks back to the stored target.
- err_clr_i clears every err_o bit. If err_clr_i and an error event occur in the same cycle, the error wins.

## Timing
- Reset values: every output is 0; actual = target = 0; every FSM is in IDLE.
- load_i is sampled at edge N. dcm_psen_o is high in cycle N+1, provided the channel is locked and the new target differs from actual. busy_o is high from cycle N+1.
- If PSDONE is sampled in cycle M, value_o updates in M+1. The next dcm_psen_o is high in M+1 (back-to-back stepping). Otherwise, done_o pulses in M+1 and busy_o drops in M+1.
- Never issue a second PSEN before PSDONE or a timeout. Minimum step period is 2 cycles plus the DCM PSDONE latency.
- dcm_psen_o and dcm_psincdec_o are registered outputs. dcm_psincdec_o holds its value outside PSEN cycles.
- A PSDONE that arrives in IDLE, STEP or UNLOCKED is ignored.

## Structure
- Shared package: state encoding, clamp function, and a TIMEOUT_W localparam derived from DONE_TIMEOUT.
- Sub-module dcm_phaseshift_chan holds the per-channel FSM, registers and counter. The top module instantiates it NUM_CH times in a generate loop and handles slicing of the packed buses and fan-out of err_clr_i.

## Test plan
- Load +5 on ch0 with a DCM model that returns PSDONE 3 cycles after PSEN -> exactly 5 PSEN pulses with psincdec=1, value_o ends at 5, one done_o pulse, err_o=0.
- Load -300 -> target clamped to -255. Model asserts ovf at step -40 -> value_o = -40, err_o=1, done_o pulse. err_clr_i then clears err_o.
- PSDONE never returns with DONE_TIMEOUT=255 -> after 255 cycles err_o=1, value_o unchanged, done_o pulse, no further PSEN.
- Mid-walk to +20 (at +8), load +3 during WAIT -> the outstanding step completes to +9, then 6 decrement steps, final value_o = 3.
- At +12, drop dcm_locked_i for 10 cycles -> value_o = 0, no PSEN while unlocked. After relock, 12 increments, value_o = 12, err_o=0.
- Simultaneous loads on ch0 (+4) and ch1 (-4) -> independent PSEN streams with correct psincdec per channel. Reset asserted mid-walk zeroes all outputs asynchronously.
